stream_arbiter_mux: RTL and testbench

//  Registered N-channel stream multiplexer with round-robin arbitration and valid/ready handshake.

---
 rtl/stream_mux_pkg.sv | 8 +
 rtl/stream_arbiter_mux_if.sv | 27 ++
 rtl/stream_arbiter_mux_rr_arbiter.sv | 34 +++
 rtl/stream_arbiter_mux.sv | 118 +++++++++++
 tb/tb_stream_arbiter_mux.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_pkg.sv
// Shared helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

    function automatic int sel_width(int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/stream_arbiter_mux_if.sv
// Producer-side and consumer-side handshake bundle of stream_arbiter_mux.
interface stream_arbiter_mux_if
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = sel_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_bus, in_valid, out_ready,
        input  in_ready, out, out_sel, out_valid
    );

    modport slave (
        input  in_bus, in_valid, out_ready,
        output in_ready, out, out_sel, out_valid
    );
endinterface

// File: rtl/stream_arbiter_mux_rr_arbiter.sv
// Combinational round-robin arbiter; the search starts one past last_idx and wraps.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    input  logic [SEL_W-1:0]    last_idx,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);
    logic [SEL_W-1:0] idx;
    logic             found;

    // grant_idx is the winner even when stalled; the one-hot grant only fires when the stage can take it
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = SEL_W'((int'(last_idx) + 1 + k) % CHANNELS);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        if (found && advance) begin
            grant[grant_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/stream_arbiter_mux.sv
// Registered N-channel round-robin stream mux; define STREAM_MUX_SKID_EN to add a skid entry
// that makes in_ready independent of out_ready.
module stream_arbiter_mux
    import stream_mux_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input logic                clock,
    input logic                reset,
    stream_arbiter_mux_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
    } beat_t;

    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grantIdx;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [WIDTH-1:0]    chData [CHANNELS];
    logic                canAccept, inXfer, outFire;
    beat_t               inBeat, outBeat_q, outBeat_d;
    logic                outValid_q, outValid_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            chData[i] = bus.in_bus[(CHANNELS-i)*WIDTH-1 -: WIDTH];
        end
    end

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .req       (bus.in_valid),
        .advance   (canAccept),
        .last_idx  (last_q),
        .grant     (grant),
        .grant_idx (grantIdx)
    );

    assign inXfer      = |grant;
    assign outFire     = outValid_q & bus.out_ready;
    assign inBeat.data = chData[grantIdx];
    assign inBeat.sel  = grantIdx;
    assign last_d      = inXfer ? grantIdx : last_q;

`ifdef STREAM_MUX_SKID_EN
    beat_t skidBeat_q, skidBeat_d;
    logic  skidFull_q, skidFull_d;

    assign canAccept = ~skidFull_q;

    // A full skid entry always drains into the output register before new input is accepted
    always_comb begin
        outBeat_d  = outBeat_q;
        outValid_d = outValid_q;
        skidBeat_d = skidBeat_q;
        skidFull_d = skidFull_q;
        if (skidFull_q) begin
            if (outFire) begin
                outBeat_d  = skidBeat_q;
                skidFull_d = 1'b0;
            end
        end else if (inXfer) begin
            if (!outValid_q || outFire) begin
                outBeat_d  = inBeat;
                outValid_d = 1'b1;
            end else begin
                skidBeat_d = inBeat;
                skidFull_d = 1'b1;
            end
        end else if (outFire) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skidBeat_q <= '0;
            skidFull_q <= 1'b0;
        end else begin
            skidBeat_q <= skidBeat_d;
            skidFull_q <= skidFull_d;
        end
    end
`else
    assign canAccept = ~outValid_q | bus.out_ready;

    always_comb begin
        outBeat_d  = outBeat_q;
        outValid_d = outValid_q;
        if (inXfer) begin
            outBeat_d  = inBeat;
            outValid_d = 1'b1;
        end else if (outFire) begin
            outValid_d = 1'b0;
        end
    end
`endif

    // Reset leaves the pointer on the last channel so channel 0 wins first
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outBeat_q  <= '0;
            outValid_q <= 1'b0;
            last_q     <= SEL_W'(CHANNELS - 1);
        end else begin
            outBeat_q  <= outBeat_d;
            outValid_q <= outValid_d;
            last_q     <= last_d;
        end
    end

    assign bus.in_ready  = grant;
    assign bus.out       = outBeat_q.data;
    assign bus.out_sel   = outBeat_q.sel;
    assign bus.out_valid = outValid_q;
endmodule

// File: tb/tb_stream_arbiter_mux.sv
// Self-checking bench for stream_arbiter_mux: queue-based reference model plus directed literal checks.
module tb_stream_arbiter_mux;
    localparam int WIDTH    = 32;
    localparam int CHANNELS = 4;
`ifdef STREAM_MUX_SKID_EN
    localparam int          CAPACITY       = 2;
    localparam logic [3:0]  STALL_READY    = 4'b1000;
`else
    localparam int          CAPACITY       = 1;
    localparam logic [3:0]  STALL_READY    = 4'b0000;
`endif

    typedef struct {
        logic [31:0] data;
        int          sel;
    } beatT;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checkCount = 0;
    int   failCount  = 0;
    logic [WIDTH-1:0] chData [CHANNELS];
    beatT modelQueue[$];
    int   modelLast = CHANNELS - 1;
    logic [3:0] modelReadyNow;
    int   modelGrantNow;

    stream_arbiter_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) busIf ();

    stream_arbiter_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (busIf.slave)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        for (int i = 0; i < CHANNELS; i++) begin
            busIf.in_bus[(CHANNELS-i)*WIDTH-1 -: WIDTH] = chData[i];
        end
        busIf.in_valid  = valid;
        busIf.out_ready = ready;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // First valid channel after the last accepted one, wrapping around; -1 when nobody asks
    function automatic int modelGrant();
        for (int k = 1; k <= CHANNELS; k++) begin
            int c;
            c = (modelLast + k) % CHANNELS;
            if (busIf.in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Two-beat capacity accepts whenever a slot is free; one-beat accepts if empty or draining
    function automatic logic [3:0] modelReady();
        int   g;
        logic room;
        g = modelGrant();
`ifdef STREAM_MUX_SKID_EN
        room = (modelQueue.size() < 2);
`else
        room = (modelQueue.size() == 0) || busIf.out_ready;
`endif
        return (room && g >= 0) ? 4'(1 << g) : 4'b0000;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            modelQueue.delete();
            modelLast = CHANNELS - 1;
        end else begin
            modelReadyNow = modelReady();
            modelGrantNow = modelGrant();
            if (modelQueue.size() > 0 && busIf.out_ready) void'(modelQueue.pop_front());
            if (modelReadyNow != 4'b0000) begin
                modelQueue.push_back('{busIf.in_bus[(CHANNELS-modelGrantNow)*WIDTH-1 -: WIDTH], modelGrantNow});
                modelLast = modelGrantNow;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("model in_ready", 32'(busIf.in_ready), 32'(modelReady()));
            checkOutput("model out_valid", 32'(busIf.out_valid), 32'(modelQueue.size() > 0));
            if (modelQueue.size() > 0) begin
                checkOutput("model out", busIf.out, modelQueue[0].data);
                checkOutput("model out_sel", 32'(busIf.out_sel), 32'(modelQueue[0].sel));
            end
        end
    end

    initial begin
        for (int i = 0; i < CHANNELS; i++) chData[i] = '0;
        applyStimulus(4'b0000, 1'b0);
        repeat (2) tick();
        reset = 1'b0;

        // Reset mid-stream while a beat is held
        for (int i = 0; i < CHANNELS; i++) chData[i] = 32'hA0 + 32'(i);
        applyStimulus(4'b1111, 1'b1);
        repeat (3) tick();
        checkOutput("pre-reset out", busIf.out, 32'hA2);
        checkOutput("pre-reset out_valid", 32'(busIf.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("reset out", busIf.out, 32'h0);
        checkOutput("reset out_sel", 32'(busIf.out_sel), 32'd0);
        checkOutput("reset out_valid", 32'(busIf.out_valid), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("post-reset ch0 first", 32'(busIf.in_ready), 32'b0001);

        // All channels valid, consumer always ready
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("rr out", busIf.out, 32'hA0 + 32'(k % 4));
            checkOutput("rr out_sel", 32'(busIf.out_sel), 32'(k % 4));
            checkOutput("rr out_valid", 32'(busIf.out_valid), 32'd1);
        end

        // Single channel
        chData[2] = 32'hDEAD_BEEF;
        applyStimulus(4'b0100, 1'b1);
        #1;
        checkOutput("ch2 in_ready", 32'(busIf.in_ready), 32'b0100);
        tick();
        checkOutput("ch2 out", busIf.out, 32'hDEAD_BEEF);
        checkOutput("ch2 out_sel", 32'(busIf.out_sel), 32'd2);

        // Consumer stall
        for (int i = 0; i < CHANNELS; i++) chData[i] = 32'hA0 + 32'(i);
        applyStimulus(4'b1111, 1'b0);
        #1;
        checkOutput("stall first in_ready", 32'(busIf.in_ready), 32'(STALL_READY));
        repeat (5) begin
            tick();
            checkOutput("stall out", busIf.out, 32'hDEAD_BEEF);
            checkOutput("stall out_sel", 32'(busIf.out_sel), 32'd2);
            checkOutput("stall full in_ready", 32'(busIf.in_ready), 32'd0);
        end
        applyStimulus(4'b1111, 1'b1);
        tick();
        checkOutput("resume out", busIf.out, 32'hA3);
        checkOutput("resume out_sel", 32'(busIf.out_sel), 32'd3);
        applyStimulus(4'b0000, 1'b1);
        repeat (3) tick();

        // Offered-but-stalled grant, then the producer withdraws
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chData[0] = 32'hC0;
        chData[1] = 32'hC1;
        chData[3] = 32'hC3;
        applyStimulus(4'b0001, 1'b0);
        repeat (CAPACITY) tick();
        applyStimulus(4'b0010, 1'b0);
        #1;
        checkOutput("ch1 stalled in_ready", 32'(busIf.in_ready), 32'd0);
        tick();
        checkOutput("ch1 still stalled", 32'(busIf.in_ready), 32'd0);
        applyStimulus(4'b1000, 1'b1);
`ifdef STREAM_MUX_SKID_EN
        tick();
`endif
        #1;
        checkOutput("ch3 granted", 32'(busIf.in_ready), 32'b1000);
        tick();
        checkOutput("ch3 out", busIf.out, 32'hC3);
        checkOutput("ch3 out_sel", 32'(busIf.out_sel), 32'd3);

        // Random traffic against the model
        applyStimulus(4'b0000, 1'b1);
        repeat (2) tick();
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < CHANNELS; i++) chData[i] = $urandom;
            applyStimulus(4'($urandom), $urandom_range(0, 3) != 0);
            tick();
        end
        applyStimulus(4'b0000, 1'b1);
        repeat (4) tick();
        checkOutput("drained out_valid", 32'(busIf.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
